// File: rtl/counter_8bit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : counter_8bit (with bit cell counter_8bit_cell)                 |
// | Brief    : WIDTH-bit binary up-counter with async active-low clear and    |
// |            preset; per-bit structural or behavioural implementation.     |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+

// One counter bit: a flip-flop with async clear (dominant) and async preset.
module counter_8bit_cell (
    output logic q,
    input  logic clock,
    input  logic preset,
    input  logic clear,
    input  logic d
);

    logic r_q;

    always_ff @(posedge clock or negedge clear or negedge preset) begin
        if (!clear) begin
            r_q <= 1'b0;
        end else if (!preset) begin
            r_q <= 1'b1;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

module counter_8bit #(
    parameter int WIDTH      = 8,
    parameter bit STRUCTURAL = 1'b1
) (
    output logic [WIDTH-1:0] q,
    input  logic             clock,
    input  logic             preset,
    input  logic             clear
);

    logic [WIDTH-1:0] w_q;

    generate
        if (STRUCTURAL) begin : g_struct
            // Ripple half-adder chain: bit i toggles when all lower bits are 1.
            logic [WIDTH-1:0] w_carry;
            assign w_carry[0] = 1'b1;

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic w_d;
                assign w_d = w_q[i] ^ w_carry[i];

                if (i < WIDTH - 1) begin : g_carry
                    assign w_carry[i+1] = w_q[i] & w_carry[i];
                end

                counter_8bit_cell u_cell (
                    .q      (w_q[i]),
                    .clock  (clock),
                    .preset (preset),
                    .clear  (clear),
                    .d      (w_d)
                );
            end
        end else begin : g_behav
            logic [WIDTH-1:0] r_count;

            always_ff @(posedge clock or negedge clear or negedge preset) begin
                if (!clear) begin
                    r_count <= '0;
                end else if (!preset) begin
                    r_count <= '1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign w_q = r_count;
        end
    endgenerate

    assign q = w_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_8bit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_counter_8bit                                               |
// | Brief    : Directed self-checking bench for counter_8bit (both forms).   |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_counter_8bit;

    logic       clock;
    logic       preset;
    logic       clear;
    logic [7:0] q_s;
    logic [7:0] q_b;

    int vectors;
    int miscompares;

    counter_8bit #(.WIDTH(8), .STRUCTURAL(1'b1)) dut (
        .q      (q_s),
        .clock  (clock),
        .preset (preset),
        .clear  (clear)
    );

    counter_8bit #(.WIDTH(8), .STRUCTURAL(1'b0)) dut_beh (
        .q      (q_b),
        .clock  (clock),
        .preset (preset),
        .clear  (clear)
    );

    initial begin
        clock = 1'b0;
        forever #50 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic [7:0] exp);
        check({tag, "_struct"}, q_s, exp);
        check({tag, "_behav"}, q_b, exp);
    endtask

    initial begin
        logic [7:0] exp;
        vectors     = 0;
        miscompares = 0;

        // Clear held for 200 units with the clock running.
        clear  = 1'b0;
        preset = 1'b1;
        #1;
        check_both("reset", 8'h00);
        repeat (2) begin
            @(posedge clock); #1;
            check_both("clear_hold", 8'h00);
        end

        // Preset asserted between edges takes effect at once and survives edges.
        @(negedge clock);
        clear  = 1'b1;
        preset = 1'b0;
        #1;
        check_both("preset_async", 8'hFF);
        repeat (2) begin
            @(posedge clock); #1;
            check_both("preset_hold", 8'hFF);
        end

        // Clear dominates preset; then release back to counting from zero.
        @(negedge clock);
        clear = 1'b0;
        #1;
        check_both("clear_over_preset", 8'h00);
        preset = 1'b1;
        #1;
        check_both("preset_release", 8'h00);
        @(negedge clock);
        clear = 1'b1;
        #1;
        check_both("release_no_edge", 8'h00);

        exp = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            exp = exp + 8'h01;
            check_both("count", exp);
        end

        // Wrap from all-ones.
        @(negedge clock);
        preset = 1'b0;
        #1;
        check_both("wrap_preset", 8'hFF);
        @(posedge clock); #1;
        check_both("wrap_preset_edge", 8'hFF);
        @(negedge clock);
        preset = 1'b1;
        @(posedge clock); #1;
        check_both("wrap_first", 8'h00);
        @(posedge clock); #1;
        check_both("wrap_second", 8'h01);

        // Mid-count async override at 8'h37.
        repeat (54) @(posedge clock);
        #1;
        check_both("reach_37", 8'h37);
        #24;
        clear = 1'b0;
        #1;
        check_both("mid_clear", 8'h00);
        preset = 1'b0;
        #1;
        check_both("mid_both", 8'h00);
        @(posedge clock); #1;
        check_both("both_edge", 8'h00);
        @(negedge clock);
        preset = 1'b1;
        #1;
        check_both("rel_preset", 8'h00);
        clear = 1'b1;
        #1;
        check_both("rel_clear", 8'h00);
        @(posedge clock); #1;
        check_both("rel_first_edge", 8'h01);

        // Long run across several wraps; both forms against the bench model.
        exp = 8'h01;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock); #1;
            exp = exp + 8'h01;
            check_both("equiv", exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
